float_add_pipe: RTL and testbench
=================================

Name: float_add_pipe

Overview:
Parametrised, 3-stage pipelined IEEE-754 floating-point adder/subtractor. It replaces the single-cycle half-precision combinational adder in the FPU datapath. It adds:
- Configurable exponent and fraction widths
- Add or subtract op select
- Round-to-nearest-even with guard/round/sticky bits
- Full subnormal support and exception flags
- A valid/ready handshake with backpressure

Parameters:
EXPONENT_WIDTH, 5, exponent field width (5 = half, 8 = single)
FRACTION_WIDTH, 10, stored fraction width (10 = half, 23 = single)
FLOAT_WIDTH, 1+EXPONENT_WIDTH+FRACTION_WIDTH, derived operand width; do not override

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  synchronous active-high reset
in_valid  input  1  operands and op valid this cycle
in_ready  output  1  stage 1 can accept
float1  input  FLOAT_WIDTH  operand A
float2  input  FLOAT_WIDTH  operand B
op  input  1  0 = A+B, 1 = A-B (B sign inverted)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  FLOAT_WIDTH  rounded result
flag_invalid  output  1  NaN operand or inf-inf
flag_overflow  output  1  rounded magnitude exceeded max finite
flag_inexact  output  1  any nonzero bit discarded by rounding or overflow

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST). On RST all stage valid bits clear. out_valid, result and all flags read 0 the cycle after RST is sampled high. In-flight operations are discarded; reset mid-stall drops them too.
- Handshake:
  - stall = out_valid & ~out_ready; in_ready = ~stall.
  - When stall is 0 every stage advances, including bubbles. When stall is 1 every stage holds.
  - A transfer occurs on in_valid & in_ready.
  - result and flags remain stable while out_valid & ~out_ready.
- Latency: exactly 3 cycles from accepted input to out_valid with no stall. Throughput is 1 per cycle.
- Stage 1 (swap/align):
  - Apply op to B's sign.
  - Order operands by magnitude {exp,frac}; ties pick A.
  - Form significands with hidden bit = (exp != 0).
  - Effective exponent of a subnormal is 1.
  - Right-shift the smaller significand by the exponent difference into a FRACTION_WIDTH+4 wide field (hidden, fraction, G, R, S). Shifted-out bits OR into S. Shifts >= FRACTION_WIDTH+3 leave only the sticky bit.
  - Classify special cases and register them.
- Stage 2 (add): add on equal signs, subtract larger minus smaller on differing signs. Carry-out is retained. Result sign is the larger operand's sign.
- Stage 3 (normalise/round/pack):
  - On carry, shift right 1 (sticky-preserving) and increment the exponent.
  - Otherwise left-shift by the leading-zero count, limited so the exponent does not drop below 1. Reaching exponent 1 without a hidden bit encodes a subnormal (exp field 0).
  - Round RNE: increment when G & (R | S | lsb). Rounding carry renormalises.
  - Exponent reaching all-ones gives overflow: signed infinity, flag_overflow=1, flag_inexact=1.
- Special cases, highest priority first:
  1. Any NaN input, or inf + (-inf) after op: result is canonical NaN (sign 0, exp all-ones, fraction MSB 1, rest 0), flag_invalid=1.
  2. Any infinity: that infinity with its effective sign.
  3. Exact zero result from a nonzero difference or (+0)+(-0): +0. (-0)+(-0) gives -0.
- Flags are per-result and are not sticky.

Optional Feature:
FPU_ADD_FTZ_EN: when defined, subnormal inputs are treated as zero of the same sign in stage 1. Results that would be subnormal are flushed to signed zero with flag_inexact=1, and the leading-zero shift limit logic is omitted. When undefined, full gradual-underflow behaviour as above.

Test Plan:
1. Half defaults, op=0, 0x3C00 + 0x4000 -> result 0x4200 after exactly 3 cycles; flags 0.
2. Rounding: 0x3C00 + 0x1000 (1 + half ulp) -> 0x3C00 with inexact=1. 0x3C00 + 0x1600 (1 + 1.5 ulp) -> 0x3C02 with inexact=1.
3. Exceptions:
   - 0x7BFF + 0x7BFF -> 0x7C00, overflow=1, inexact=1.
   - 0x7C00 + 0xFC00 -> 0x7E00, invalid=1.
   - 0x7E01 + 0x3C00 -> 0x7E00, invalid=1.
4. Cancellation and subnormals:
   - op=1, 0x3C00 - 0x3C00 -> 0x0000.
   - 0x0001 + 0x0001 -> 0x0002.
   - 0x0400 - 0x0001 -> 0x03FF, exact.
   - With FPU_ADD_FTZ_EN: 0x0001 + 0x0001 -> 0x0000, inexact=1.
5. Backpressure: stream 5 back-to-back adds with out_ready low for cycles 4-6 -> in_ready low during the stall, no result lost or duplicated, results in order and stable while held.
6. Reset: assert RST with 3 ops in flight -> next cycle out_valid=0 and result=0; subsequent op 0x3C00 + 0x3C00 -> 0x4000 three cycles after acceptance.

Source files
------------

// File: rtl/float_add_pipe.sv
`default_nettype none
// ============================================================================
// Module      : float_add_pipe
// Description : Three-stage pipelined IEEE-754 adder/subtractor with
//               parametrised exponent/fraction widths, round-to-nearest-even,
//               gradual underflow, exception flags and valid/ready backpressure.
//               Define FPU_ADD_FTZ_EN to flush subnormal inputs and results
//               to signed zero.
// Revision    : 1.0 - initial release
// ============================================================================
module float_add_pipe #(
    parameter int EXPONENT_WIDTH = 5,
    parameter int FRACTION_WIDTH = 10,
    parameter int FLOAT_WIDTH    = 1 + EXPONENT_WIDTH + FRACTION_WIDTH
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FLOAT_WIDTH-1:0] float1,
    input  logic [FLOAT_WIDTH-1:0] float2,
    input  logic                   op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FLOAT_WIDTH-1:0] result,
    output logic                   flag_invalid,
    output logic                   flag_overflow,
    output logic                   flag_inexact
);

    // Significand field: hidden, fraction, guard, round, sticky
    localparam int c_SIG_W = FRACTION_WIDTH + 4;
    // Exponent arithmetic width with headroom for carry and normalisation
    localparam int c_XW    = EXPONENT_WIDTH + 2;
    localparam logic [EXPONENT_WIDTH-1:0] c_EXP_MAX = '1;

    logic w_advance;

    assign w_advance = ~(out_valid & ~out_ready);
    assign in_ready  = w_advance;

    // ------------------------------------------------------------------
    // Stage 1: unpack, order by magnitude, align smaller operand
    // ------------------------------------------------------------------
    logic                      w_sign_a, w_sign_b;
    logic [EXPONENT_WIDTH-1:0] w_exp_a, w_exp_b;
    logic [FRACTION_WIDTH-1:0] w_frac_a, w_frac_b;
    logic [FRACTION_WIDTH-1:0] w_man_a, w_man_b;
    logic                      w_ftz_in;
    logic                      w_a_large;
    logic                      w_sign_l, w_sign_s;
    logic [EXPONENT_WIDTH-1:0] w_exp_l, w_exp_s, w_eexp_l, w_eexp_s, w_diff;
    logic [FRACTION_WIDTH-1:0] w_man_l, w_man_s;
    logic [c_SIG_W-1:0]        w_sig_l, w_sig_s, w_sig_s_shift, w_sig_s_al;
    logic                      w_shift_lost;
    logic                      w_nan_a, w_nan_b, w_inf_a, w_inf_b;
    logic                      w_invalid, w_inf, w_inf_sign, w_zero_sign;

    // Stage-1 combinational unpack/swap/align and special-case classification
    always_comb begin
        w_sign_a = float1[FLOAT_WIDTH-1];
        w_sign_b = float2[FLOAT_WIDTH-1] ^ op;
        w_exp_a  = float1[FLOAT_WIDTH-2:FRACTION_WIDTH];
        w_exp_b  = float2[FLOAT_WIDTH-2:FRACTION_WIDTH];
        w_frac_a = float1[FRACTION_WIDTH-1:0];
        w_frac_b = float2[FRACTION_WIDTH-1:0];

`ifdef FPU_ADD_FTZ_EN
        // Subnormal inputs become zero of the same sign; a discarded nonzero
        // fraction makes the result inexact.
        w_man_a  = (w_exp_a == '0) ? '0 : w_frac_a;
        w_man_b  = (w_exp_b == '0) ? '0 : w_frac_b;
        w_ftz_in = ((w_exp_a == '0) && (w_frac_a != '0)) ||
                   ((w_exp_b == '0) && (w_frac_b != '0));
`else
        w_man_a  = w_frac_a;
        w_man_b  = w_frac_b;
        w_ftz_in = 1'b0;
`endif

        // Ties choose A so equal magnitudes keep A's sign as the result sign
        w_a_large = ({w_exp_a, w_man_a} >= {w_exp_b, w_man_b});
        w_sign_l  = w_a_large ? w_sign_a : w_sign_b;
        w_sign_s  = w_a_large ? w_sign_b : w_sign_a;
        w_exp_l   = w_a_large ? w_exp_a  : w_exp_b;
        w_exp_s   = w_a_large ? w_exp_b  : w_exp_a;
        w_man_l   = w_a_large ? w_man_a  : w_man_b;
        w_man_s   = w_a_large ? w_man_b  : w_man_a;

        // Subnormals share the minimum normal exponent
        w_eexp_l  = (w_exp_l == '0) ? EXPONENT_WIDTH'(1) : w_exp_l;
        w_eexp_s  = (w_exp_s == '0) ? EXPONENT_WIDTH'(1) : w_exp_s;
        w_diff    = w_eexp_l - w_eexp_s;

        w_sig_l   = {(w_exp_l != '0), w_man_l, 3'b000};
        w_sig_s   = {(w_exp_s != '0), w_man_s, 3'b000};

        w_sig_s_shift = w_sig_s >> w_diff;
        w_shift_lost  = |(w_sig_s & ~({c_SIG_W{1'b1}} << w_diff));
        if (32'(w_diff) >= 32'(c_SIG_W - 1)) begin
            w_sig_s_al = {{(c_SIG_W-1){1'b0}}, |w_sig_s};
        end else begin
            w_sig_s_al = {w_sig_s_shift[c_SIG_W-1:1], w_sig_s_shift[0] | w_shift_lost};
        end

        w_nan_a     = (w_exp_a == c_EXP_MAX) && (w_frac_a != '0);
        w_nan_b     = (w_exp_b == c_EXP_MAX) && (w_frac_b != '0);
        w_inf_a     = (w_exp_a == c_EXP_MAX) && (w_frac_a == '0);
        w_inf_b     = (w_exp_b == c_EXP_MAX) && (w_frac_b == '0);
        w_invalid   = w_nan_a | w_nan_b | (w_inf_a & w_inf_b & (w_sign_a ^ w_sign_b));
        w_inf       = w_inf_a | w_inf_b;
        w_inf_sign  = w_inf_a ? w_sign_a : w_sign_b;
        // An exact zero keeps a negative sign only when both addends are -0
        w_zero_sign = w_sign_a & w_sign_b;
    end

    logic                      r_s1_valid, r_s1_sign, r_s1_sub;
    logic [EXPONENT_WIDTH-1:0] r_s1_exp;
    logic [c_SIG_W-1:0]        r_s1_sig_l, r_s1_sig_s;
    logic                      r_s1_invalid, r_s1_inf, r_s1_inf_sign, r_s1_zero_sign, r_s1_ftz_in;

    // Stage-1 pipeline register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1_valid     <= 1'b0;
            r_s1_sign      <= 1'b0;
            r_s1_sub       <= 1'b0;
            r_s1_exp       <= '0;
            r_s1_sig_l     <= '0;
            r_s1_sig_s     <= '0;
            r_s1_invalid   <= 1'b0;
            r_s1_inf       <= 1'b0;
            r_s1_inf_sign  <= 1'b0;
            r_s1_zero_sign <= 1'b0;
            r_s1_ftz_in    <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid     <= in_valid;
            r_s1_sign      <= w_sign_l;
            r_s1_sub       <= w_sign_l ^ w_sign_s;
            r_s1_exp       <= w_eexp_l;
            r_s1_sig_l     <= w_sig_l;
            r_s1_sig_s     <= w_sig_s_al;
            r_s1_invalid   <= w_invalid;
            r_s1_inf       <= w_inf;
            r_s1_inf_sign  <= w_inf_sign;
            r_s1_zero_sign <= w_zero_sign;
            r_s1_ftz_in    <= w_ftz_in;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: significand add / subtract (larger minus smaller)
    // ------------------------------------------------------------------
    logic [c_SIG_W:0] w_sum;

    // Stage-2 combinational add with carry-out retained
    always_comb begin
        if (r_s1_sub) begin
            w_sum = {1'b0, r_s1_sig_l} - {1'b0, r_s1_sig_s};
        end else begin
            w_sum = {1'b0, r_s1_sig_l} + {1'b0, r_s1_sig_s};
        end
    end

    logic                      r_s2_valid, r_s2_sign;
    logic [EXPONENT_WIDTH-1:0] r_s2_exp;
    logic [c_SIG_W:0]          r_s2_sum;
    logic                      r_s2_invalid, r_s2_inf, r_s2_inf_sign, r_s2_zero_sign, r_s2_ftz_in;

    // Stage-2 pipeline register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s2_valid     <= 1'b0;
            r_s2_sign      <= 1'b0;
            r_s2_exp       <= '0;
            r_s2_sum       <= '0;
            r_s2_invalid   <= 1'b0;
            r_s2_inf       <= 1'b0;
            r_s2_inf_sign  <= 1'b0;
            r_s2_zero_sign <= 1'b0;
            r_s2_ftz_in    <= 1'b0;
        end else if (w_advance) begin
            r_s2_valid     <= r_s1_valid;
            r_s2_sign      <= r_s1_sign;
            r_s2_exp       <= r_s1_exp;
            r_s2_sum       <= w_sum;
            r_s2_invalid   <= r_s1_invalid;
            r_s2_inf       <= r_s1_inf;
            r_s2_inf_sign  <= r_s1_inf_sign;
            r_s2_zero_sign <= r_s1_zero_sign;
            r_s2_ftz_in    <= r_s1_ftz_in;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: normalise, round to nearest even, pack, apply exceptions
    // ------------------------------------------------------------------
    logic [c_XW-1:0] w_lzc;

    // Leading-zero count of the non-carry sum (c_SIG_W when all zero)
    always_comb begin
        w_lzc = c_XW'(c_SIG_W);
        for (int i = 0; i < c_SIG_W; i++) begin
            if (r_s2_sum[i]) begin
                w_lzc = c_XW'(c_SIG_W - 1 - i);
            end
        end
    end

    logic [c_XW-1:0]           w_exp_in, w_shift, w_exp_n, w_exp_f;
    logic [c_SIG_W-1:0]        w_norm;
    logic                      w_sum_zero, w_flush, w_inc, w_grs, w_ovf;
    logic [FRACTION_WIDTH+1:0] w_rounded;
    logic [FRACTION_WIDTH-1:0] w_frac_f;
    logic [FLOAT_WIDTH-1:0]    w_res;
    logic                      w_res_inv, w_res_ovf, w_res_inx;

    // Stage-3 combinational normalise/round/pack
    always_comb begin
        w_exp_in   = {2'b00, r_s2_exp};
        w_sum_zero = (r_s2_sum == '0);
        w_flush    = 1'b0;
        w_shift    = '0;
        w_norm     = '0;
        w_exp_n    = w_exp_in;

        if (r_s2_sum[c_SIG_W]) begin
            // Carry: one place right, folding the dropped bit into sticky
            w_norm  = {r_s2_sum[c_SIG_W:2], r_s2_sum[1] | r_s2_sum[0]};
            w_exp_n = w_exp_in + c_XW'(1);
        end else begin
`ifdef FPU_ADD_FTZ_EN
            w_shift = w_lzc;
            w_flush = !w_sum_zero && (w_lzc >= w_exp_in);
`else
            // Stop at exponent 1; anything left without a hidden bit is subnormal
            w_shift = (w_lzc < w_exp_in) ? w_lzc : (w_exp_in - c_XW'(1));
`endif
            w_norm  = r_s2_sum[c_SIG_W-1:0] << w_shift;
            w_exp_n = w_exp_in - w_shift;
        end

        w_grs     = w_norm[2] | w_norm[1] | w_norm[0];
        w_inc     = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rounded = {1'b0, w_norm[c_SIG_W-1:3]} + {{(FRACTION_WIDTH+1){1'b0}}, w_inc};

        if (w_rounded[FRACTION_WIDTH+1]) begin
            w_exp_f  = w_exp_n + c_XW'(1);
            w_frac_f = w_rounded[FRACTION_WIDTH:1];
        end else begin
            // No hidden bit here means a subnormal (or zero) encoding
            w_exp_f  = w_rounded[FRACTION_WIDTH] ? w_exp_n : '0;
            w_frac_f = w_rounded[FRACTION_WIDTH-1:0];
        end
        w_ovf = (w_exp_f >= {2'b00, c_EXP_MAX});

        w_res_inv = 1'b0;
        w_res_ovf = 1'b0;
        w_res_inx = 1'b0;
        if (r_s2_invalid) begin
            w_res     = {1'b0, c_EXP_MAX, 1'b1, {(FRACTION_WIDTH-1){1'b0}}};
            w_res_inv = 1'b1;
        end else if (r_s2_inf) begin
            w_res = {r_s2_inf_sign, c_EXP_MAX, {FRACTION_WIDTH{1'b0}}};
        end else if (w_flush) begin
            w_res     = {r_s2_sign, {(FLOAT_WIDTH-1){1'b0}}};
            w_res_inx = 1'b1;
        end else if (w_ovf) begin
            w_res     = {r_s2_sign, c_EXP_MAX, {FRACTION_WIDTH{1'b0}}};
            w_res_ovf = 1'b1;
            w_res_inx = 1'b1;
        end else begin
            w_res     = {(w_sum_zero ? r_s2_zero_sign : r_s2_sign),
                         w_exp_f[EXPONENT_WIDTH-1:0], w_frac_f};
            w_res_inx = w_grs | r_s2_ftz_in;
        end
    end

    logic                   r_out_valid, r_inv, r_ovf, r_inx;
    logic [FLOAT_WIDTH-1:0] r_result;

    // Output register; bubbles load zeros so idle outputs stay quiet
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_inv       <= 1'b0;
            r_ovf       <= 1'b0;
            r_inx       <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= r_s2_valid;
            r_result    <= r_s2_valid ? w_res : '0;
            r_inv       <= r_s2_valid & w_res_inv;
            r_ovf       <= r_s2_valid & w_res_ovf;
            r_inx       <= r_s2_valid & w_res_inx;
        end
    end

    assign out_valid     = r_out_valid;
    assign result        = r_result;
    assign flag_invalid  = r_inv;
    assign flag_overflow = r_ovf;
    assign flag_inexact  = r_inx;

endmodule
`default_nettype wire

// File: tb/tb_float_add_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_float_add_pipe
// Description : Scoreboard bench for float_add_pipe (half precision defaults).
//               Expected results are queued at acceptance and compared when the
//               DUT hands a result over. Honours FPU_ADD_FTZ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_float_add_pipe;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid, in_ready, op;
    logic        out_valid, out_ready;
    logic [15:0] float1, float2, result;
    logic        flag_invalid, flag_overflow, flag_inexact;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int stall_cnt = 0;

    typedef struct {
        logic [15:0] res;
        logic [2:0]  flags;   // {invalid, overflow, inexact}
        bit          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        o;
        logic [15:0] r;
        logic [2:0]  f;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    float_add_pipe dut (
        .CLK           (CLK),
        .RST           (RST),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .float1        (float1),
        .float2        (float2),
        .op            (op),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .flag_invalid  (flag_invalid),
        .flag_overflow (flag_overflow),
        .flag_inexact  (flag_inexact)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cycle <= cycle + 1;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cycle);
        end
    endtask

    // Output monitor: compares handed-over results and watches stalls
    initial begin : monitor
        exp_t        e;
        logic [18:0] held;
        bit          held_valid;
        held_valid = 0;
        held       = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                held_valid = 0;
            end else begin
                if (out_valid && !out_ready) begin
                    stall_cnt++;
                    check_value("in_ready_stall", {31'd0, in_ready}, 32'd0);
                    if (held_valid)
                        check_value("hold_stable",
                                    {13'd0, flag_invalid, flag_overflow, flag_inexact, result},
                                    {13'd0, held});
                    held       = {flag_invalid, flag_overflow, flag_inexact, result};
                    held_valid = 1;
                end else begin
                    held_valid = 0;
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check_value("spurious_output", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check_value("result", {16'd0, result}, {16'd0, e.res});
                        check_value("flags", {29'd0, flag_invalid, flag_overflow, flag_inexact},
                                    {29'd0, e.flags});
                        if (e.lat)
                            check_value("latency", cycle - e.acc, 32'd3);
                    end
                end
            end
        end
    end

    // Present one operation and hold it until accepted; leaves time at posedge+1
    task automatic drive_op(input logic [15:0] a, input logic [15:0] b, input logic o,
                            input logic [15:0] er, input logic [2:0] ef, input bit lat);
        exp_t e;
        int   n;
        bit   done;
        float1   = a;
        float2   = b;
        op       = o;
        in_valid = 1'b1;
        n        = 0;
        done     = 0;
        while (!done) begin
            @(negedge CLK);
            if (in_ready) begin
                e.res   = er;
                e.flags = ef;
                e.lat   = lat;
                e.acc   = cycle;
                sb_q.push_back(e);
                done = 1;
            end else begin
                n++;
                if (n > 50) begin
                    check_value("accept_timeout", 32'd0, 32'd1);
                    done = 1;
                end
            end
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) until every queued expectation has been consumed
    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check_value("drain", sb_q.size(), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        RST       = 1'b1;
        in_valid  = 1'b0;
        float1    = '0;
        float2    = '0;
        op        = 1'b0;
        out_ready = 1'b1;

        vecs.push_back('{16'h3C00, 16'h4000, 1'b0, 16'h4200, 3'b000});
        vecs.push_back('{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 3'b001});
        vecs.push_back('{16'h3C00, 16'h1600, 1'b0, 16'h3C02, 3'b001});
        vecs.push_back('{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b011});
        vecs.push_back('{16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 3'b100});
        vecs.push_back('{16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 3'b100});
        vecs.push_back('{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b000});
`ifdef FPU_ADD_FTZ_EN
        vecs.push_back('{16'h0001, 16'h0001, 1'b0, 16'h0000, 3'b001});
        vecs.push_back('{16'h0400, 16'h0001, 1'b1, 16'h0400, 3'b001});
        vecs.push_back('{16'h03FF, 16'h0001, 1'b0, 16'h0000, 3'b001});
        vecs.push_back('{16'h0800, 16'h07FF, 1'b1, 16'h0000, 3'b001});
`else
        vecs.push_back('{16'h0001, 16'h0001, 1'b0, 16'h0002, 3'b000});
        vecs.push_back('{16'h0400, 16'h0001, 1'b1, 16'h03FF, 3'b000});
        vecs.push_back('{16'h03FF, 16'h0001, 1'b0, 16'h0400, 3'b000});
        vecs.push_back('{16'h0800, 16'h07FF, 1'b1, 16'h0001, 3'b000});
`endif
        vecs.push_back('{16'h4000, 16'h3C00, 1'b1, 16'h3C00, 3'b000});
        vecs.push_back('{16'h3C00, 16'hC000, 1'b0, 16'hBC00, 3'b000});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h8000, 3'b000});
        vecs.push_back('{16'h0000, 16'h8000, 1'b0, 16'h0000, 3'b000});
        vecs.push_back('{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 3'b000});
        vecs.push_back('{16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 3'b000});
        vecs.push_back('{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 3'b001});
        vecs.push_back('{16'h3C00, 16'h0001, 1'b0, 16'h3C00, 3'b001});
        vecs.push_back('{16'h5640, 16'h5640, 1'b0, 16'h5A40, 3'b000});
        vecs.push_back('{16'h3C00, 16'h3BFF, 1'b1, 16'h1000, 3'b000});

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_value("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check_value("reset_result", {16'd0, result}, 32'd0);
        check_value("reset_flags", {29'd0, flag_invalid, flag_overflow, flag_inexact}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check_value("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge CLK);
        #1;

        // Directed vectors, back to back, no backpressure
        foreach (vecs[i])
            drive_op(vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].r, vecs[i].f, 1'b1);
        wait_drain();

        // Backpressure: five streamed adds with the consumer stalling mid-stream
        fork
            begin
                drive_op(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000, 1'b0);
                drive_op(16'h4000, 16'h3C00, 1'b0, 16'h4200, 3'b000, 1'b0);
                drive_op(16'h4400, 16'h3C00, 1'b0, 16'h4500, 3'b000, 1'b0);
                drive_op(16'h4500, 16'h3C00, 1'b0, 16'h4600, 3'b000, 1'b0);
                drive_op(16'h4600, 16'h3C00, 1'b0, 16'h4700, 3'b000, 1'b0);
            end
            begin
                repeat (3) @(posedge CLK);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge CLK);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check_value("stall_seen", {31'd0, (stall_cnt > 0)}, 32'd1);

        // Reset with three operations in flight
        drive_op(16'h3C00, 16'h4000, 1'b0, 16'h4200, 3'b000, 1'b0);
        drive_op(16'h4000, 16'h4000, 1'b0, 16'h4400, 3'b000, 1'b0);
        drive_op(16'h4400, 16'h3C00, 1'b0, 16'h4500, 3'b000, 1'b0);
        RST = 1'b1;
        sb_q.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check_value("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        check_value("rst_mid_result", {16'd0, result}, 32'd0);
        repeat (4) begin
            @(negedge CLK);
            check_value("rst_flushed", {31'd0, out_valid}, 32'd0);
        end
        @(posedge CLK);
        #1;
        drive_op(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000, 1'b1);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
